// File: rtl/ddr_req_queue.sv
// Front-end request queue for the LPDDR controller: buffers user requests in a
// FIFO, issues one command at a time paced on a synchronized BUSY, and returns read bursts.
module ddr_req_queue #(
  parameter  int BURST_LENGTH = 16,
  parameter  int DEPTH        = 4,
  parameter  int TIMEOUT      = 64,
  localparam int DATA_W       = 16 * BURST_LENGTH
) (
  input  logic              SYS_CLK_100M,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [24:0]       REQ_ADDR,
  input  logic [3:0]        REQ_LEN,
  input  logic [DATA_W-1:0] REQ_DATA,
  output logic              CMD_WRITE,
  output logic              CMD_READ,
  output logic [1:0]        CMD_BA,
  output logic [12:0]       CMD_ROW,
  output logic [9:0]        CMD_COL,
  output logic [3:0]        CMD_LEN,
  output logic [DATA_W-1:0] CMD_DATA,
  input  logic              CTRL_BUSY,
  input  logic [DATA_W-1:0] CTRL_RD_DATA,
  output logic              RD_VALID,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              ERR
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic              wr;
    logic [24:0]       addr;
    logic [3:0]        len;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  req_t          mem_q [DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, empty, push, pop;
  logic [1:0]    sync_q;
  logic          busy_s;

  state_t            state_q, state_d;
  logic              cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d, is_rd_q, is_rd_d;
  logic [1:0]        ba_q, ba_d;
  logic [12:0]       row_q, row_d;
  logic [9:0]        col_q, col_d;
  logic [3:0]        len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d, rd_data_q, rd_data_d;
  logic [CW-1:0]     tmo_q, tmo_d;
  logic              rd_valid_q, rd_valid_d, err_q, err_d;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign REQ_READY = !full;
  assign push      = REQ_VALID && !full;
  assign head      = mem_q[rd_ptr_q];
  assign busy_s    = sync_q[1];

  always_ff @(posedge SYS_CLK_100M) begin
    if (push) mem_q[wr_ptr_q] <= '{wr: REQ_WRITE, addr: REQ_ADDR, len: REQ_LEN, data: REQ_DATA};
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_rd_d   = cmd_rd_q;
    is_rd_d    = is_rd_q;
    ba_d       = ba_q;
    row_d      = row_q;
    col_d      = col_q;
    len_d      = len_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (!empty && !busy_s) begin
        pop      = 1'b1;
        cmd_wr_d = head.wr;
        cmd_rd_d = !head.wr;
        is_rd_d  = !head.wr;
        ba_d     = head.addr[24:23];
        row_d    = head.addr[22:10];
        col_d    = head.addr[9:0];
        len_d    = head.len;
        data_d   = head.data;
        tmo_d    = '0;
        state_d  = ISSUE;
      end
      ISSUE: begin
        if (busy_s) begin
          cmd_wr_d = 1'b0;
          cmd_rd_d = 1'b0;
          state_d  = WAIT_DONE;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          // Controller never acknowledged: drop the command and flag it.
          cmd_wr_d = 1'b0;
          cmd_rd_d = 1'b0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: if (!busy_s) begin
        if (is_rd_q) begin
          rd_data_d  = CTRL_RD_DATA;
          rd_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK_100M or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      cmd_wr_q   <= 1'b0;
      cmd_rd_q   <= 1'b0;
      is_rd_q    <= 1'b0;
      ba_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      len_q      <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q      <= cnt_d;
      sync_q     <= {sync_q[0], CTRL_BUSY};
      state_q    <= state_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      is_rd_q    <= is_rd_d;
      ba_q       <= ba_d;
      row_q      <= row_d;
      col_q      <= col_d;
      len_q      <= len_d;
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign CMD_WRITE = cmd_wr_q;
  assign CMD_READ  = cmd_rd_q;
  assign CMD_BA    = ba_q;
  assign CMD_ROW   = row_q;
  assign CMD_COL   = col_q;
  assign CMD_LEN   = len_q;
  assign CMD_DATA  = data_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_DATA   = rd_data_q;
  assign ERR       = err_q;

endmodule
